alu181_seq: RTL and testbench
=============================

Name: alu181_seq

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit 74181-style ALU.
- Operates on WIDTH-bit operands by pushing SLICES 4-bit slices per clock through a registered carry chain, least-significant slice first.
- Uses valid/ready handshakes on input and output, and returns result, carry, zero and overflow flags.
- Sits between the datapath operand registers and the writeback stage.

Parameters:
- WIDTH, 16: operand/result width; must be a multiple of 4 and at least 4.
- SLICES, 1: 4-bit slices evaluated per cycle; must divide WIDTH/4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- s  in  4  function select
- m  in  1  1 = logic mode, 0 = arithmetic mode
- c_in  in  1  carry in, active-high (+1); ignored when m=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- f  out  WIDTH  result
- c_out  out  1  carry out of MSB; 0 in logic mode
- zero  out  1  f equals 0
- ovf  out  1  signed overflow (carry into MSB xor carry out); 0 in logic mode

Behaviour:
- Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, f=0, c_out=0, zero=0, ovf=0, internal carry=0, slice counter=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, s, m, c_in; load carry=c_in&~m; set counter=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, evaluate slices counter*SLICES through counter*SLICES+SLICES-1, rippling carry combinationally between them.
  - Write the resulting nibbles into the f register and store the final carry.
  - After N=WIDTH/(4*SLICES) cycles, go to DONE with f, c_out, zero and ovf registered.
  - out_valid rises on the N-th edge after the accepting edge.
- State DONE:
  - out_valid=1, in_ready=0.
  - Outputs are held stable until out_ready=1; then go to IDLE.
  - A new request cannot be accepted in the same cycle (no bypass).
- Logic mode (m=1), bitwise, no carry. Results for s=0..15:
  - 0: ~A
  - 1: ~(A|B)
  - 2: ~A&B
  - 3: 0
  - 4: ~(A&B)
  - 5: ~B
  - 6: A^B
  - 7: A&~B
  - 8: ~A|B
  - 9: ~(A^B)
  - 10: B
  - 11: A&B
  - 12: all-ones
  - 13: A|~B
  - 14: A|B
  - 15: A
- Arithmetic mode (m=0): F = P + Q + c_in across the full width, with P and Q formed per nibble. Results for s=0..15 (F1 = all-ones nibble):
  - 0: A + 0
  - 1: (A|B) + 0
  - 2: (A|~B) + 0
  - 3: 0 + F1
  - 4: A + (A&~B)
  - 5: (A|B) + (A&~B)
  - 6: A + ~B
  - 7: (A&~B) + F1
  - 8: A + (A&B)
  - 9: A + B
  - 10: (A|~B) + (A&B)
  - 11: (A&B) + F1
  - 12: A + A
  - 13: (A|B) + A
  - 14: (A|~B) + A
  - 15: A + F1
- Arithmetic consequences:
  - s=6 with c_in=1 is A-B; c_out=1 means no borrow.
  - s=15 with c_in=0 is A-1.
- Width rules:
  - All sums are modulo 2^WIDTH; c_out is bit WIDTH.
  - zero is computed on the full registered f.
- Boundary conditions:
  - rst asserted in RUN or DONE aborts the operation; the pending result is discarded and all outputs return to their reset values.
  - in_valid while busy is ignored; inputs are not sampled.
  - Inputs changing after acceptance have no effect.
  - WIDTH=4, SLICES=1 gives N=1.

Decomposition:
- Package alu181_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - alu_op_t typedef for s.
  - Function returning P and Q per nibble from (s, a_nib, b_nib).
  - NIBBLE=4 constant.
- Sub-module alu181_slice: combinational 4-bit slice with inputs s, m, a_nib, b_nib, cin and outputs f_nib, cout, c_msb_in (carry into bit 3, used for ovf). The top instantiates SLICES copies in a ripple chain.

Test Plan:
- WIDTH=16, m=0, s=9, a=0x1234, b=0x0FFF, c_in=1 -> f=0x2234, c_out=0, zero=0, ovf=0; out_valid on the 4th edge after accept.
- m=0, s=9, a=0xFFFF, b=0x0001, c_in=0 -> f=0x0000, c_out=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0001 -> f=0x8000, ovf=1.
- m=0, s=6, c_in=1, a=0x0005, b=0x0007 -> f=0xFFFE, c_out=0 (borrow). Swap operands -> f=0x0002, c_out=1.
- m=1, s=6, a=0xF0F0, b=0xFF00 -> f=0x0FF0, c_out=0, ovf=0. Repeat with SLICES=4 -> result on the 1st edge after accept.
- Hold out_ready=0 for 10 cycles with in_valid=1 and new operands -> f stable, in_ready=0, second request accepted only after the out_ready handshake.
- Assert rst for 1 cycle in RUN (after 2 slices) -> next cycle IDLE, in_ready=1, out_valid=0, f=0; a following operation computes correctly.

Source files
------------

// File: rtl/alu181_pkg.sv
// Shared types and per-nibble function tables for the sequential 74181-style ALU.
// The arithmetic P/Q operand pair and the logic result are defined once here.
package alu181_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [3:0] alu_op_t;

  typedef struct packed {
    logic [NIBBLE-1:0] p;
    logic [NIBBLE-1:0] q;
  } pq_t;

  // Arithmetic mode adds P + Q + carry; Q = all-ones nibble acts as -1 per nibble.
  function automatic pq_t alu_pq(input alu_op_t s, input logic [NIBBLE-1:0] a,
                                 input logic [NIBBLE-1:0] b);
    pq_t r;
    r.p = a;
    r.q = '0;
    case (s)
      4'd0:  begin r.p = a;         r.q = '0;      end
      4'd1:  begin r.p = a | b;     r.q = '0;      end
      4'd2:  begin r.p = a | ~b;    r.q = '0;      end
      4'd3:  begin r.p = '0;        r.q = '1;      end
      4'd4:  begin r.p = a;         r.q = a & ~b;  end
      4'd5:  begin r.p = a | b;     r.q = a & ~b;  end
      4'd6:  begin r.p = a;         r.q = ~b;      end
      4'd7:  begin r.p = a & ~b;    r.q = '1;      end
      4'd8:  begin r.p = a;         r.q = a & b;   end
      4'd9:  begin r.p = a;         r.q = b;       end
      4'd10: begin r.p = a | ~b;    r.q = a & b;   end
      4'd11: begin r.p = a & b;     r.q = '1;      end
      4'd12: begin r.p = a;         r.q = a;       end
      4'd13: begin r.p = a | b;     r.q = a;       end
      4'd14: begin r.p = a | ~b;    r.q = a;       end
      default: begin r.p = a;       r.q = '1;      end
    endcase
    return r;
  endfunction

  function automatic logic [NIBBLE-1:0] alu_logic(input alu_op_t s, input logic [NIBBLE-1:0] a,
                                                  input logic [NIBBLE-1:0] b);
    logic [NIBBLE-1:0] r;
    r = '0;
    case (s)
      4'd0:  r = ~a;
      4'd1:  r = ~(a | b);
      4'd2:  r = ~a & b;
      4'd3:  r = '0;
      4'd4:  r = ~(a & b);
      4'd5:  r = ~b;
      4'd6:  r = a ^ b;
      4'd7:  r = a & ~b;
      4'd8:  r = ~a | b;
      4'd9:  r = ~(a ^ b);
      4'd10: r = b;
      4'd11: r = a & b;
      4'd12: r = '1;
      4'd13: r = a | ~b;
      4'd14: r = a | b;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit ALU slice; chained by the top to form a ripple carry path.
// c_msb_in is the carry into bit 3, needed for signed overflow on the top slice.
module alu181_slice
  import alu181_pkg::*;
(
  input  logic [3:0]        s,
  input  logic              m,
  input  logic [NIBBLE-1:0] a_nib,
  input  logic [NIBBLE-1:0] b_nib,
  input  logic              cin,
  output logic [NIBBLE-1:0] f_nib,
  output logic              cout,
  output logic              c_msb_in
);

  pq_t             pq;
  logic [NIBBLE:0] sum;

  always_comb begin
    pq  = alu_pq(alu_op_t'(s), a_nib, b_nib);
    sum = {1'b0, pq.p} + {1'b0, pq.q} + {{NIBBLE{1'b0}}, cin};
    if (m) begin
      f_nib    = alu_logic(alu_op_t'(s), a_nib, b_nib);
      cout     = 1'b0;
      c_msb_in = 1'b0;
    end else begin
      f_nib    = sum[NIBBLE-1:0];
      cout     = sum[NIBBLE];
      // Sum bit 3 is p3 ^ q3 ^ carry-in-to-bit-3, so the carry can be recovered.
      c_msb_in = pq.p[NIBBLE-1] ^ pq.q[NIBBLE-1] ^ sum[NIBBLE-1];
    end
  end

endmodule

// File: rtl/alu181_seq.sv
// Multi-cycle WIDTH-bit ALU: SLICES nibbles per clock, LSB chunk first, carry kept
// in a register between cycles, valid/ready handshake on both sides.
module alu181_seq
  import alu181_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SLICES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  localparam int CHUNK = SLICES * NIBBLE;
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0]     LAST      = CW'(STEPS - 1);
  localparam logic [SLICES-1:0] TOP_SLICE = SLICES'(1) << (SLICES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d, opB_q, opB_d, f_q, f_d;
  alu_op_t          op_q, op_d;
  logic             mode_q, mode_d, carry_q, carry_d;
  logic             cOut_q, cOut_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;

  logic              accept, lastStep, msbIn;
  logic [SLICES:0]   chainC;
  logic [SLICES-1:0] chainMsb;
  logic [CHUNK-1:0]  chunkF;
  logic [WIDTH-1:0]  chunkWide;

  assign accept   = in_valid && in_ready;
  assign lastStep = (state_q == RUN) && (count_q == LAST);

  // Operands are shifted down each cycle, so the active chunk is always the low bits.
  assign chainC[0] = carry_q;
  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    alu181_slice u_slice (
      .s        (op_q),
      .m        (mode_q),
      .a_nib    (opA_q[k*NIBBLE +: NIBBLE]),
      .b_nib    (opB_q[k*NIBBLE +: NIBBLE]),
      .cin      (chainC[k]),
      .f_nib    (chunkF[k*NIBBLE +: NIBBLE]),
      .cout     (chainC[k+1]),
      .c_msb_in (chainMsb[k])
    );
  end

  // Only the most significant slice's internal carry matters for overflow.
  assign msbIn     = |(chainMsb & TOP_SLICE);
  assign chunkWide = WIDTH'(chunkF);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (count_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Result nibbles enter at the top of f and shift down, landing in place after STEPS cycles.
  always_comb begin
    opA_d   = opA_q;
    opB_d   = opB_q;
    op_d    = op_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    count_d = count_q;
    f_d     = f_q;
    cOut_d  = cOut_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    if (accept) begin
      opA_d   = a;
      opB_d   = b;
      op_d    = alu_op_t'(s);
      mode_d  = m;
      carry_d = c_in & ~m;
      count_d = '0;
    end else if (state_q == RUN) begin
      opA_d   = opA_q >> CHUNK;
      opB_d   = opB_q >> CHUNK;
      carry_d = chainC[SLICES];
      f_d     = (f_q >> CHUNK) | (chunkWide << (WIDTH - CHUNK));
      count_d = count_q + CW'(1);
      if (lastStep) begin
        count_d = '0;
        cOut_d  = chainC[SLICES];
        zero_d  = (f_d == '0);
        ovf_d   = msbIn ^ chainC[SLICES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q   <= '0;
      opB_q   <= '0;
      op_q    <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      count_q <= '0;
      f_q     <= '0;
      cOut_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      count_q <= count_d;
      f_q     <= f_d;
      cOut_q  <= cOut_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign f     = f_q;
  assign c_out = cOut_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_alu181_seq.sv
// Directed bench for alu181_seq: a 1-slice and a 4-slice 16-bit instance share inputs
// and the handshake, so every operation is checked on both datapath widths.
module tb_alu181_seq;

  logic        clk = 1'b0;
  logic        rst, inValid, outReady, m, cIn;
  logic [15:0] a, b;
  logic [3:0]  s;

  logic        inReady, outValid, cOut, zero, ovf;
  logic [15:0] f;
  logic        wInReady, wOutValid, wCOut, wZero, wOvf;
  logic [15:0] wF;

  int compared   = 0;
  int mismatched = 0;
  int lat, latW;

  always #5 clk = ~clk;

  alu181_seq #(.WIDTH(16), .SLICES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .s(s), .m(m), .c_in(cIn),
    .out_valid(outValid), .out_ready(outReady),
    .f(f), .c_out(cOut), .zero(zero), .ovf(ovf)
  );

  alu181_seq #(.WIDTH(16), .SLICES(4)) dutWide (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(wInReady),
    .a(a), .b(b), .s(s), .m(m), .c_in(cIn),
    .out_valid(wOutValid), .out_ready(outReady),
    .f(wF), .c_out(wCOut), .zero(wZero), .ovf(wOvf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Count edges until the narrow instance reports done; also note when the wide one did.
  task automatic waitDone();
    lat  = 0;
    latW = 0;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (wOutValid && latW == 0) latW = lat;
    end
  endtask

  // Present one request, scramble the inputs right after acceptance, then wait for the result.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic [3:0] sv, input logic mv, input logic cv);
    a = av; b = bv; s = sv; m = mv; cIn = cv; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    a = ~av; b = ~bv; s = ~sv; m = ~mv; cIn = ~cv;
    waitDone();
  endtask

  task automatic checkResult(input string tag, input logic [15:0] expF, input logic expC,
                             input logic expZ, input logic expO);
    checkOutput({tag, ".f"}, f, expF);
    checkOutput({tag, ".c_out"}, cOut, expC);
    checkOutput({tag, ".zero"}, zero, expZ);
    checkOutput({tag, ".ovf"}, ovf, expO);
    checkOutput({tag, ".latency"}, lat, 4);
    checkOutput({tag, ".wide.f"}, wF, expF);
    checkOutput({tag, ".wide.c_out"}, wCOut, expC);
    checkOutput({tag, ".wide.ovf"}, wOvf, expO);
    checkOutput({tag, ".wide.latency"}, latW, 1);
  endtask

  task automatic finishOp();
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; cIn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset.in_ready", inReady, 1'b1);
    checkOutput("reset.out_valid", outValid, 1'b0);
    checkOutput("reset.f", f, 16'h0000);
    checkOutput("reset.c_out", cOut, 1'b0);
    checkOutput("reset.zero", zero, 1'b0);
    checkOutput("reset.ovf", ovf, 1'b0);

    applyStimulus(16'h1234, 16'h0FFF, 4'd9, 1'b0, 1'b1);
    checkResult("add_cin", 16'h2234, 1'b0, 1'b0, 1'b0);
    finishOp();

    applyStimulus(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0);
    checkResult("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    finishOp();

    applyStimulus(16'h7FFF, 16'h0001, 4'd9, 1'b0, 1'b0);
    checkResult("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1);
    finishOp();

    applyStimulus(16'h0005, 16'h0007, 4'd6, 1'b0, 1'b1);
    checkResult("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    finishOp();

    applyStimulus(16'h0007, 16'h0005, 4'd6, 1'b0, 1'b1);
    checkResult("sub_noborrow", 16'h0002, 1'b1, 1'b0, 1'b0);
    finishOp();

    applyStimulus(16'h0000, 16'hABCD, 4'd15, 1'b0, 1'b0);
    checkResult("dec_zero", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    finishOp();

    applyStimulus(16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b1);
    checkResult("logic_xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    finishOp();

    applyStimulus(16'h1234, 16'h5678, 4'd3, 1'b1, 1'b0);
    checkResult("logic_zero", 16'h0000, 1'b0, 1'b1, 1'b0);
    finishOp();

    applyStimulus(16'hC3A5, 16'h0F0F, 4'd13, 1'b1, 1'b0);
    checkResult("logic_or_nb", 16'hF3F5, 1'b0, 1'b0, 1'b0);
    finishOp();

    // Result held in DONE while a new request waits; it must not be taken early.
    applyStimulus(16'h0001, 16'h0002, 4'd9, 1'b0, 1'b0);
    checkResult("hold_first", 16'h0003, 1'b0, 1'b0, 1'b0);
    a = 16'h1111; b = 16'h2222; s = 4'd9; m = 1'b0; cIn = 1'b0; inValid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("hold.f", f, 16'h0003);
    checkOutput("hold.in_ready", inReady, 1'b0);
    checkOutput("hold.out_valid", outValid, 1'b1);
    checkOutput("hold.wide.f", wF, 16'h0003);
    finishOp();
    checkOutput("hold.release.in_ready", inReady, 1'b1);
    checkOutput("hold.release.out_valid", outValid, 1'b0);
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("hold.second.in_ready", inReady, 1'b0);
    waitDone();
    checkResult("hold_second", 16'h3333, 1'b0, 1'b0, 1'b0);
    finishOp();

    // Abort mid-operation with a one-cycle reset.
    a = 16'h1234; b = 16'h0FFF; s = 4'd9; m = 1'b0; cIn = 1'b1; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort.in_ready", inReady, 1'b1);
    checkOutput("abort.out_valid", outValid, 1'b0);
    checkOutput("abort.f", f, 16'h0000);
    checkOutput("abort.c_out", cOut, 1'b0);
    checkOutput("abort.zero", zero, 1'b0);
    checkOutput("abort.ovf", ovf, 1'b0);
    checkOutput("abort.wide.out_valid", wOutValid, 1'b0);
    checkOutput("abort.wide.f", wF, 16'h0000);

    applyStimulus(16'h0100, 16'h0200, 4'd9, 1'b0, 1'b0);
    checkResult("after_abort", 16'h0300, 1'b0, 1'b0, 1'b0);
    finishOp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
